// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command sequencer.
// Holds the FSM state enum, command geometry and the default inter-byte timeout.
package uart_cmd_pkg;

  localparam int unsigned CMD_W         = 24;
  localparam int unsigned BYTES_PER_CMD = 3;
  localparam int unsigned DEF_TO_CYCLES = 1000000;

  typedef enum logic [1:0] {
    WaitB1,
    WaitB2,
    WaitB3,
    Hold
  } state_e;

endpackage

// File: rtl/uart_cmd_seq_if.sv
// Bundle between UART receiver / command consumer and uart_cmd_seq.
//   rx_rdy, rx_data : byte from the receiver
//   clr_rx_rdy      : byte consumed acknowledge back to the receiver
//   cmd, cmd_rdy    : assembled command and its valid flag
//   clr_cmd_rdy     : consumer acknowledge of cmd
//   to_err          : partial command discarded pulse
//   busy            : sequencer is mid-command or holding a command
// slave is the sequencer side, master the surrounding system side.
interface uart_cmd_seq_if
  import uart_cmd_pkg::*;
();

  logic             rx_rdy;
  logic [7:0]       rx_data;
  logic             clr_rx_rdy;
  logic [CMD_W-1:0] cmd;
  logic             cmd_rdy;
  logic             clr_cmd_rdy;
  logic             to_err;
  logic             busy;

  modport slave (
    input  rx_rdy, rx_data, clr_cmd_rdy,
    output clr_rx_rdy, cmd, cmd_rdy, to_err, busy
  );

  modport master (
    output rx_rdy, rx_data, clr_cmd_rdy,
    input  clr_rx_rdy, cmd, cmd_rdy, to_err, busy
  );

endinterface

// File: rtl/uart_cmd_timer.sv
// Inter-byte timeout counter for uart_cmd_seq (exists only with CMD_TIMEOUT_EN).
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : restart count from zero (has priority)
//   en         : count this cycle
//   expire     : count has reached TO_CYCLES-1 while enabled
`ifdef CMD_TIMEOUT_EN
module uart_cmd_timer #(
  parameter int unsigned TO_CYCLES = 16,
  parameter int unsigned TO_W      = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [TO_W-1:0] LastCount = TO_W'(TO_CYCLES - 1);

  logic [TO_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expire = en && (count_q == LastCount);

endmodule
`endif

// File: rtl/uart_cmd_seq.sv
// Assembles three received UART bytes into a 24-bit command {b1, b2, b3}.
// Bytes are acknowledged combinationally on clr_rx_rdy; the finished command is
// held with cmd_rdy until clr_cmd_rdy, during which new bytes are back-pressured.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : uart_cmd_seq_if.slave (receiver and consumer handshakes)
// Optional macro CMD_TIMEOUT_EN: discard a partial command after TO_CYCLES idle
// cycles and pulse to_err; without it to_err is tied low.
module uart_cmd_seq
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TO_CYCLES = DEF_TO_CYCLES,
  parameter int unsigned TO_W      = 20
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_cmd_seq_if.slave  bus
);

  if (TO_CYCLES == 0 || longint'(TO_CYCLES) >= (longint'(1) << TO_W)) begin : g_bad_cfg
    $error("TO_CYCLES must be nonzero and fit in TO_W bits");
  end

  state_e           state_q, state_d;
  logic [7:0]       b1_q, b1_d, b2_q, b2_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic             cmd_rdy_q, cmd_rdy_d;
  logic             capture;
  logic             timeout;

  // Gated by rst_n so nothing is acknowledged while reset is asserted.
  assign capture = rst_n && bus.rx_rdy && (state_q != Hold);

  always_comb begin
    state_d   = state_q;
    b1_d      = b1_q;
    b2_d      = b2_q;
    cmd_d     = cmd_q;
    cmd_rdy_d = cmd_rdy_q;
    case (state_q)
      WaitB1: begin
        if (capture) begin
          b1_d    = bus.rx_data;
          state_d = WaitB2;
        end
      end
      WaitB2: begin
        if (capture) begin
          b2_d    = bus.rx_data;
          state_d = WaitB3;
        end else if (timeout) begin
          b1_d    = '0;
          state_d = WaitB1;
        end
      end
      WaitB3: begin
        if (capture) begin
          cmd_d     = {b1_q, b2_q, bus.rx_data};
          cmd_rdy_d = 1'b1;
          state_d   = Hold;
        end else if (timeout) begin
          b1_d    = '0;
          b2_d    = '0;
          state_d = WaitB1;
        end
      end
      Hold: begin
        // A byte pending alongside the clear is taken next cycle as byte 1.
        if (bus.clr_cmd_rdy) begin
          cmd_rdy_d = 1'b0;
          state_d   = WaitB1;
        end
      end
      default: state_d = WaitB1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= WaitB1;
      b1_q      <= '0;
      b2_q      <= '0;
      cmd_q     <= '0;
      cmd_rdy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      b1_q      <= b1_d;
      b2_q      <= b2_d;
      cmd_q     <= cmd_d;
      cmd_rdy_q <= cmd_rdy_d;
    end
  end

  assign bus.clr_rx_rdy = capture;
  assign bus.cmd        = cmd_q;
  assign bus.cmd_rdy    = cmd_rdy_q;
  assign bus.busy       = (state_q != WaitB1);

`ifdef CMD_TIMEOUT_EN
  logic expire;
  logic to_err_q;

  uart_cmd_timer #(
    .TO_CYCLES (TO_CYCLES),
    .TO_W      (TO_W)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (capture | timeout),
    .en     ((state_q == WaitB2) || (state_q == WaitB3)),
    .expire (expire)
  );

  // A byte landing on the expiry cycle wins over the timeout.
  assign timeout = expire && !capture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_err_q <= 1'b0;
    end else begin
      to_err_q <= timeout;
    end
  end

  assign bus.to_err = to_err_q;
`else
  assign timeout    = 1'b0;
  assign bus.to_err = 1'b0;
`endif

endmodule
